// File: rtl/pixel_mixer_fifo.sv
// Background/window and sprite pixel FIFOs with DMG-style mixing; one pixel out per T-cycle, output registered.
// Optional `define PIXEL_MIXER_BG_MASTER_EN: bg_enable_in low blanks the background colour for output and priority.
module pixel_mixer_fifo #(
   parameter int COLOR_W = 2,
   parameter int DEPTH   = 16,
   parameter int TILE_W  = 8
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        tclk_in,
   input  logic                        rd_en_in,
   input  logic                        flush_in,
   input  logic [2:0]                  discard_in,
   input  logic [TILE_W*COLOR_W-1:0]   bg_row_in,
   input  logic                        bg_load_in,
   output logic                        bg_ready_out,
   input  logic [TILE_W*COLOR_W-1:0]   spr_row_in,
   input  logic                        spr_pal_in,
   input  logic                        spr_prio_in,
   input  logic                        spr_load_in,
   input  logic                        bg_enable_in,
   output logic [COLOR_W-1:0]          pixel_out,
   output logic                        pixel_src_out,
   output logic                        pixel_pal_out,
   output logic                        pixel_valid_out,
   output logic [$clog2(DEPTH):0]      bg_count_out
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int SCNT_W = $clog2(TILE_W) + 1;
   localparam int SPR_W  = COLOR_W + 2;   // {colour, pal, prio}

   logic [COLOR_W-1:0] bg_mem_q  [DEPTH];
   logic [COLOR_W-1:0] bg_mem_d  [DEPTH];
   logic [SPR_W-1:0]   spr_mem_q [TILE_W];
   logic [SPR_W-1:0]   spr_mem_d [TILE_W];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     bg_count_q, bg_count_d;
   logic [SCNT_W-1:0]  spr_count_q, spr_count_d;
   logic [2:0]         disc_cnt_q, disc_cnt_d;
   logic [COLOR_W-1:0] pixel_q, pixel_d;
   logic               pixel_src_q, pixel_src_d;
   logic               pixel_pal_q, pixel_pal_d;
   logic               pixel_valid_q, pixel_valid_d;

   logic               bg_ready, pop, bg_push;
   logic [COLOR_W-1:0] bg_col, spr_col;
   logic               spr_pal, spr_prio, spr_wins;

   assign bg_ready = bg_count_q <= (PTR_W+1)'(DEPTH - TILE_W);
   assign pop      = tclk_in && rd_en_in && (bg_count_q != '0) && !spr_load_in && !flush_in;
   assign bg_push  = tclk_in && !flush_in && bg_load_in && bg_ready;

`ifdef PIXEL_MIXER_BG_MASTER_EN
   assign bg_col = bg_enable_in ? bg_mem_q[rd_ptr_q] : '0;
`else
   logic unused_bg_enable;
   assign unused_bg_enable = bg_enable_in;
   assign bg_col = bg_mem_q[rd_ptr_q];
`endif

   // An empty sprite FIFO behaves as a transparent overlay.
   assign {spr_col, spr_pal, spr_prio} = (spr_count_q != '0) ? spr_mem_q[0] : '0;
   assign spr_wins = (spr_col != '0) && !(spr_prio && (bg_col != '0));

   always_comb begin
      bg_mem_d      = bg_mem_q;
      spr_mem_d     = spr_mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      bg_count_d    = bg_count_q;
      spr_count_d   = spr_count_q;
      disc_cnt_d    = disc_cnt_q;
      pixel_d       = pixel_q;
      pixel_src_d   = pixel_src_q;
      pixel_pal_d   = pixel_pal_q;
      pixel_valid_d = 1'b0;

      if (tclk_in && flush_in) begin
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         bg_count_d  = '0;
         spr_count_d = '0;
         disc_cnt_d  = discard_in;
         for (int i = 0; i < TILE_W; i++) spr_mem_d[i] = '0;
         // A row arriving with the flush lands in the freshly cleared FIFO.
         if (bg_load_in) begin
            for (int i = 0; i < TILE_W; i++)
               bg_mem_d[PTR_W'(i)] = bg_row_in[i*COLOR_W +: COLOR_W];
            wr_ptr_d   = PTR_W'(TILE_W);
            bg_count_d = (PTR_W+1)'(TILE_W);
         end
      end else if (tclk_in) begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (spr_count_q != '0) begin
               for (int i = 0; i < TILE_W-1; i++) spr_mem_d[i] = spr_mem_q[i+1];
               spr_mem_d[TILE_W-1] = '0;
               spr_count_d = spr_count_q - 1'b1;
            end
            if (disc_cnt_q != '0) begin
               disc_cnt_d = disc_cnt_q - 1'b1;
            end else begin
               pixel_valid_d = 1'b1;
               pixel_d       = spr_wins ? spr_col : bg_col;
               pixel_src_d   = spr_wins;
               pixel_pal_d   = spr_wins & spr_pal;
            end
         end
         if (bg_push) begin
            for (int i = 0; i < TILE_W; i++)
               bg_mem_d[wr_ptr_q + PTR_W'(i)] = bg_row_in[i*COLOR_W +: COLOR_W];
            wr_ptr_d = wr_ptr_q + PTR_W'(TILE_W);
         end
         bg_count_d = bg_count_q + (bg_push ? (PTR_W+1)'(TILE_W) : '0) - {{PTR_W{1'b0}}, pop};
         // Earlier OAM entries keep their non-transparent pixels.
         if (spr_load_in) begin
            for (int i = 0; i < TILE_W; i++) begin
               if ((SCNT_W'(i) >= spr_count_q) || (spr_mem_q[i][SPR_W-1 -: COLOR_W] == '0))
                  spr_mem_d[i] = {spr_row_in[i*COLOR_W +: COLOR_W], spr_pal_in, spr_prio_in};
            end
            spr_count_d = SCNT_W'(TILE_W);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < DEPTH; i++)  bg_mem_q[i]  <= '0;
         for (int i = 0; i < TILE_W; i++) spr_mem_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         bg_count_q    <= '0;
         spr_count_q   <= '0;
         disc_cnt_q    <= '0;
         pixel_q       <= '0;
         pixel_src_q   <= 1'b0;
         pixel_pal_q   <= 1'b0;
         pixel_valid_q <= 1'b0;
      end else begin
         bg_mem_q      <= bg_mem_d;
         spr_mem_q     <= spr_mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         bg_count_q    <= bg_count_d;
         spr_count_q   <= spr_count_d;
         disc_cnt_q    <= disc_cnt_d;
         pixel_q       <= pixel_d;
         pixel_src_q   <= pixel_src_d;
         pixel_pal_q   <= pixel_pal_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   assign bg_ready_out    = bg_ready;
   assign bg_count_out    = bg_count_q;
   assign pixel_out       = pixel_q;
   assign pixel_src_out   = pixel_src_q;
   assign pixel_pal_out   = pixel_pal_q;
   assign pixel_valid_out = pixel_valid_q;

endmodule

// File: doc/pixel_mixer_fifo.md
Name: pixel_mixer_fifo

Overview:
Parametrised successor to the PPU pixel pipeline front end. Holds a background/window pixel FIFO and a sprite overlay FIFO. Merges a whole tile row into either FIFO in one cycle and performs DMG-style sprite/background mixing. Emits one mixed pixel per T-cycle to the LCD, with fine-scroll discard, flush, and fetch-stall support.

Parameters:
COLOR_W, 2, bits per pixel colour index
DEPTH, 16, background FIFO entries; power of two, >= 2*TILE_W
TILE_W, 8, pixels per fetched tile row; also sprite FIFO depth

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
tclk_in  input  1  T-cycle enable; all state except reset advances only when high
rd_en_in  input  1  output enable (LCDC[7] and mode-3 active)
flush_in  input  1  clear both FIFOs (line start / window trigger)
discard_in  input  3  pixels to drop, sampled on flush (SCX[2:0])
bg_row_in  input  TILE_W*COLOR_W  tile row; pixel 0 (leftmost) in LSBs
bg_load_in  input  1  push bg row
bg_ready_out  output  1  bg row can be accepted this cycle
spr_row_in  input  TILE_W*COLOR_W  sprite row, already X-flipped, pixel 0 in LSBs
spr_pal_in  input  1  OBP0/OBP1 select for the row
spr_prio_in  input  1  OAM bit 7 (BG-over-OBJ)
spr_load_in  input  1  merge sprite row
bg_enable_in  input  1  LCDC[0]; used only with the optional feature
pixel_out  output  COLOR_W  mixed colour index
pixel_src_out  output  1  0 = background, 1 = sprite
pixel_pal_out  output  1  sprite palette select (0 when src=0)
pixel_valid_out  output  1  single-cycle strobe per pixel
bg_count_out  output  $clog2(DEPTH)+1  bg occupancy

Behaviour:
- Reset (async, rst_n_in low): FIFOs empty; read/write pointers 0; discard counter 0. All outputs 0 except bg_ready_out = 1.
- Updates occur only on clk_in edges with tclk_in = 1. Exception: pixel_valid_out clears on the next clk_in edge after any strobe, so it is one clk_in wide.
- bg_ready_out = (bg_count <= DEPTH-TILE_W), combinational from the current count. A bg_load_in while not ready is ignored; no state change.
- bg load: writes TILE_W entries at wr_ptr (wraps mod DEPTH); count += TILE_W.
- Pop condition: rd_en_in && bg_count > 0 && !spr_load_in && !flush_in.
- Pop removes one bg entry and one sprite entry if spr_count > 0.
- Simultaneous load and pop: both apply; ready is computed from the pre-pop count; net count = count + TILE_W - 1.
- Sprite merge (spr_load_in), for each i < TILE_W:
  - if i >= spr_count or stored colour == 0, slot i = {spr_row[i], spr_pal_in, spr_prio_in};
  - else the existing entry is kept (earlier OAM wins).
  - spr_count becomes TILE_W. Slot 0 is the next to pop; the sprite FIFO shifts on pop.
- Discard: on flush, disc_cnt = discard_in. A pop with disc_cnt > 0 decrements it, with no pixel_valid_out and sprite entries also dropped.
- Mix (pop with disc_cnt == 0), registered, one tclk later:
  - sprite wins iff spr colour != 0 and !(prio && bg colour != 0);
  - then pixel_out = spr colour, src = 1, pal = stored pal;
  - else pixel_out = bg colour, src = 0, pal = 0;
  - pixel_valid_out = 1.
- Flush: both counts 0, pointers 0. Simultaneous bg_load_in is applied after the clear (count = TILE_W). Simultaneous spr_load_in is dropped.
- rd_en_in low: FIFO contents hold; no pixels emitted.

Optional Feature:
PIXEL_MIXER_BG_MASTER_EN
- Defined: bg_enable_in = 0 forces the bg colour to 0 for both the output and the priority test, so sprites always win when non-transparent.
- Undefined: bg_enable_in is ignored; behaviour is as above.

Test Plan:
1. Reset, then load row 0..3 pattern {0,1,2,3,0,1,2,3} with rd_en = 1 and tclk every cycle -> 8 valid pixels in that order, src = 0; bg_count returns to 0; bg_ready_out stays 1.
2. Fill: load, load with rd_en = 0 -> count 16, bg_ready_out = 0; third load ignored; enable rd_en -> exactly 16 pixels, in order across the pointer wrap.
3. Flush with discard_in = 3, then load row {1,2,3,1,2,3,1,2} -> 5 pixels {1,2,3,1,2}; first strobe appears only after the 3 discards.
4. bg row all 2, sprite row {0,3,3,0,...} with prio = 0, pal = 1 -> output {2,3,3,2,...}; src = 1 and pal = 1 on the colour-3 pixels.
5. Same as 4 with prio = 1 -> all pixels 2, src = 0. Then with bg row all 0 and prio = 1 -> 3s shown, src = 1.
6. Two overlapping sprite merges: first {3,0,...} pal 0, second {1,1,...} pal 1 -> slot 0 keeps 3/pal 0, slot 1 = 1/pal 1; no pop occurs during either spr_load_in cycle.
